// File: rtl/uart_pkg.sv
// Shared UART RX definitions: FSM state encoding and timing constants.
// Pure declarations; no logic or latency of its own.
package uart_pkg;

    localparam int unsigned MIN_PRESCALE = 8;
    localparam int unsigned SMP_OFFSET   = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencing FSM: drives counter/sampler enables, per-bit checker strobes and frame verdict.
// All outputs registered (1-cycle latency from the decoded edge); no backpressure, line-rate driven.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6,
    parameter int BITC_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_in,
    input  logic               par_en,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic [BITC_W-1:0]  bit_cnt,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic               cnt_en,
    output logic               samp_en,
    output logic               deser_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic               frame_error
);

    localparam logic [BITC_W-1:0] LAST_DATA = BITC_W'(DATA_WIDTH);

    function automatic logic at_edge(input logic [PRESC_W-1:0] cnt,
                                     input logic [PRESC_W-1:0] target);
        return cnt == target;
    endfunction

    rx_state_e          state_q, state_d;
    logic               par_en_q, par_en_d;
    logic               par_flag_q, par_flag_d;
    logic               cnt_en_q, cnt_en_d;
    logic               deser_q, deser_d;
    logic               strt_q, strt_d;
    logic               par_q, par_d;
    logic               stp_q, stp_d;
    logic               dv_q, dv_d;
    logic               fe_q, fe_d;

    logic [PRESC_W-1:0] smp_e, pre_smp_e, dec_e, end_e;
    logic               presc_ok;

    // Strobes are decoded one edge early so the registered pulse lines up with SMP
    // and the checkers' registered results are ready by the SMP+1 verdict.
    assign smp_e     = (Prescale >> 1) + PRESC_W'(SMP_OFFSET);
    assign pre_smp_e = smp_e - PRESC_W'(1);
    assign dec_e     = smp_e + PRESC_W'(1);
    assign end_e     = Prescale - PRESC_W'(1);
    assign presc_ok  = (Prescale >= PRESC_W'(MIN_PRESCALE));

    always_comb begin
        state_d    = state_q;
        par_en_d   = par_en_q;
        par_flag_d = par_flag_q;
        deser_d    = 1'b0;
        strt_d     = 1'b0;
        par_d      = 1'b0;
        stp_d      = 1'b0;
        dv_d       = 1'b0;
        fe_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_in && presc_ok) begin
                    state_d    = START;
                    par_en_d   = par_en;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                strt_d = at_edge(edge_cnt, pre_smp_e);
                if (at_edge(edge_cnt, end_e)) state_d = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                deser_d = at_edge(edge_cnt, pre_smp_e);
                if (at_edge(edge_cnt, end_e) && bit_cnt == LAST_DATA)
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                par_d = at_edge(edge_cnt, pre_smp_e);
                if (at_edge(edge_cnt, end_e)) begin
                    par_flag_d = par_err;
                    state_d    = STOP;
                end
            end
            STOP: begin
                stp_d = at_edge(edge_cnt, pre_smp_e);
                if (at_edge(edge_cnt, dec_e)) begin
                    dv_d    = !par_flag_q && !stp_err;
                    fe_d    = par_flag_q || stp_err;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_en_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            par_en_q   <= 1'b0;
            par_flag_q <= 1'b0;
            cnt_en_q   <= 1'b0;
            deser_q    <= 1'b0;
            strt_q     <= 1'b0;
            par_q      <= 1'b0;
            stp_q      <= 1'b0;
            dv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            par_en_q   <= par_en_d;
            par_flag_q <= par_flag_d;
            cnt_en_q   <= cnt_en_d;
            deser_q    <= deser_d;
            strt_q     <= strt_d;
            par_q      <= par_d;
            stp_q      <= stp_d;
            dv_q       <= dv_d;
            fe_q       <= fe_d;
        end
    end

    assign cnt_en      = cnt_en_q;
    assign samp_en     = cnt_en_q;
    assign deser_en    = deser_q;
    assign strt_chk_en = strt_q;
    assign par_chk_en  = par_q;
    assign stp_chk_en  = stp_q;
    assign data_valid  = dv_q;
    assign frame_error = fe_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural edge/bit counter and serial line generator.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic       par_en;
    logic [5:0] Prescale;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_glitch, par_err, stp_err;
    logic       cnt_en, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, frame_error;
    logic [7:0] outs;

    int checks   = 0;
    int failures = 0;

    int n_deser, n_strt, n_par, n_stp, n_dv, n_fe, n_both, n_badpos, n_badend, n_samp_bad;
    int n_starts, first_end_cyc, second_start_cyc, last_fall_edge, rst_outs;
    logic [7:0] deser_sr;

    localparam int FAR = 1 << 20;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(6), .BITC_W(4)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .par_en(par_en),
        .Prescale(Prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .cnt_en(cnt_en), .samp_en(samp_en), .deser_en(deser_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
        .data_valid(data_valid), .frame_error(frame_error)
    );

    assign outs = {cnt_en, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                   data_valid, frame_error};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge/bit counter model: cleared while cnt_en is low, wraps at Prescale-1.
    always_ff @(posedge clk) begin
        if (reset || !cnt_en) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
        end else if (edge_cnt == 6'(Prescale - 6'd1)) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic line_bit(input int p, input bit pe, input logic [7:0] d,
                                      input bit glitch, input bit sbit, input int t);
        int b;
        b = t / p;
        if (glitch) return (t < 2) ? 1'b0 : 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pe && b == 9) return ^d;
        if (b == (pe ? 10 : 9)) return sbit;
        return 1'b1;
    endfunction

    // Drives nfr frames (the next starting the cycle a verdict appears) and tallies DUT activity.
    task automatic run_frames(input int p, input bit pe, input logic [7:0] d, input bit glitch,
                              input bit perr, input bit serr, input bit sbit,
                              input int nfr, input int rst_bit);
        int   t, left, ncyc, stop_idx, smp, prev_edge, prev_bit;
        logic prev_cnt;
        bit   rst_pending, rst_done;
        Prescale = 6'(p); par_en = pe; strt_glitch = glitch; par_err = perr; stp_err = serr;
        stop_idx = pe ? 10 : 9;
        smp      = p / 2 + 2;
        n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0; n_dv = 0; n_fe = 0; n_both = 0;
        n_badpos = 0; n_badend = 0; n_samp_bad = 0; n_starts = 0;
        first_end_cyc = -1; second_start_cyc = -1; last_fall_edge = -1; rst_outs = -1;
        deser_sr = 8'h00;
        left = nfr; t = 0; prev_edge = 0; prev_bit = 0; prev_cnt = 1'b0;
        rst_pending = 1'b0; rst_done = 1'b0;
        rx_in = line_bit(p, pe, d, glitch, sbit, 0);
        ncyc = nfr * 11 * p + 16;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            t++;
            if (rst_pending) begin
                rst_outs    = int'(outs);
                reset       = 1'b0;
                rst_pending = 1'b0;
            end
            if (samp_en !== cnt_en) n_samp_bad++;
            if (deser_en) begin
                n_deser++;
                deser_sr = {rx_in, deser_sr[7:1]};
                if (int'(edge_cnt) != smp) n_badpos++;
            end
            if (strt_chk_en) begin n_strt++; if (int'(edge_cnt) != smp) n_badpos++; end
            if (par_chk_en)  begin n_par++;  if (int'(edge_cnt) != smp) n_badpos++; end
            if (stp_chk_en)  begin n_stp++;  if (int'(edge_cnt) != smp) n_badpos++; end
            if (data_valid || frame_error) begin
                if (data_valid) n_dv++;
                if (frame_error) n_fe++;
                if (data_valid && frame_error) n_both++;
                if (prev_edge != smp + 1 || prev_bit != stop_idx || cnt_en) n_badend++;
                if (first_end_cyc < 0) first_end_cyc = cyc;
                left--;
                t = (left > 0) ? 0 : FAR;
            end
            if (cnt_en && !prev_cnt) begin
                n_starts++;
                if (n_starts == 2) second_start_cyc = cyc;
            end
            if (!cnt_en && prev_cnt) last_fall_edge = prev_edge;
            if (rst_bit > 0 && !rst_done && cnt_en && int'(bit_cnt) == rst_bit) begin
                reset       = 1'b1;
                rst_pending = 1'b1;
                rst_done    = 1'b1;
                t           = FAR;
            end
            prev_edge = int'(edge_cnt);
            prev_bit  = int'(bit_cnt);
            prev_cnt  = cnt_en;
            rx_in = line_bit(p, pe, d, glitch, sbit, t);
        end
    endtask

    initial begin
        reset = 1'b1; rx_in = 1'b1; par_en = 1'b0; Prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'(outs), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_activity", int'(outs), 0);

        // Prescale 8, no parity, 0xA5
        run_frames(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
        check("p8_deser_cnt", n_deser, 8);
        check("p8_data", int'(deser_sr), 'hA5);
        check("p8_strt_cnt", n_strt, 1);
        check("p8_par_cnt", n_par, 0);
        check("p8_stp_cnt", n_stp, 1);
        check("p8_dv", n_dv, 1);
        check("p8_fe", n_fe, 0);
        check("p8_strobe_pos", n_badpos, 0);
        check("p8_verdict_pos", n_badend, 0);
        check("p8_samp_en", n_samp_bad, 0);
        check("p8_idle_end", int'(cnt_en), 0);

        // Prescale 16, parity good, 0x3C
        run_frames(16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
        check("par_ok_par_cnt", n_par, 1);
        check("par_ok_deser_cnt", n_deser, 8);
        check("par_ok_data", int'(deser_sr), 'h3C);
        check("par_ok_dv", n_dv, 1);
        check("par_ok_fe", n_fe, 0);
        check("par_ok_pos", n_badpos + n_badend, 0);

        // Same with parity error reported
        run_frames(16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0);
        check("par_err_fe", n_fe, 1);
        check("par_err_dv", n_dv, 0);
        check("par_err_par_cnt", n_par, 1);
        check("par_err_pos", n_badpos + n_badend, 0);

        // Start glitch: line low for 2 edges
        run_frames(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0);
        check("glitch_fall_edge", last_fall_edge, 7);
        check("glitch_strt_cnt", n_strt, 1);
        check("glitch_deser_cnt", n_deser, 0);
        check("glitch_dv", n_dv, 0);
        check("glitch_fe", n_fe, 0);
        check("glitch_starts", n_starts, 1);

        // Stop bit 0 with stop error, Prescale 32
        run_frames(32, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        check("stp_fe", n_fe, 1);
        check("stp_dv", n_dv, 0);
        check("stp_verdict_pos", n_badend, 0);
        check("stp_strobe_pos", n_badpos, 0);
        check("stp_starts", n_starts, 1);
        check("stp_idle_end", int'(cnt_en), 0);

        // Back-to-back frames, Prescale 16
        run_frames(16, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0);
        check("b2b_dv", n_dv, 2);
        check("b2b_deser_cnt", n_deser, 16);
        check("b2b_gap", second_start_cyc - first_end_cyc, 1);
        check("b2b_data", int'(deser_sr), 'h96);
        check("b2b_never_both", n_both, 0);
        check("b2b_pos", n_badpos + n_badend, 0);

        // Reset in DATA at bit 4, then a clean frame
        run_frames(8, 1'b0, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1, 1, 4);
        check("rst_mid_outs", rst_outs, 0);
        check("rst_mid_dv", n_dv + n_fe, 0);
        check("rst_mid_deser", n_deser, 3);
        run_frames(8, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
        check("post_rst_dv", n_dv, 1);
        check("post_rst_data", int'(deser_sr), 'h3C);
        check("post_rst_pos", n_badpos + n_badend, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
